// File: rtl/sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl
// Turns one sky130_sram_1kbyte_1r1w_8x1024_8 macro into a 1024-deep,
// first-word-fall-through byte FIFO. Pushes go straight to the macro write
// port; the read port prefetches into a 3-entry output buffer that feeds
// the pop interface.
//
// Optional feature macro: SFC_FLUSH_EN adds the 'flush' input (synchronous
// clear of all FIFO state; in_ready stays high).
//
// Ports
//   clk0, rstb0            clock, synchronous active-low reset
//   in_valid/in_data       push side, accepted when in_valid && in_ready
//   in_ready               room left in the SRAM
//   out_valid/out_data     head byte, popped when out_valid && out_ready
//   out_ready              pop request
//   level                  bytes held (SRAM + in flight + buffer), 0..1027
//   sram_csb0/web0/addr0/din0   macro write port (registered)
//   sram_csb1/addr1        macro read port (registered)
//   sram_dout1             macro read data
//   flush                  only with SFC_FLUSH_EN
// -----------------------------------------------------------------------------
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int MACRO_AW   = 12
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [MACRO_AW-1:0]   sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [MACRO_AW-1:0]   sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
`ifdef SFC_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_mem_cnt;
  logic [CW-1:0]         r_rd_avail;
  logic                  r_push_d1;
  logic [1:0]            r_pipe;       // [0] = issued last edge, [1] = data on dout1 now
  logic [1:0]            r_buf_head;
  logic [1:0]            r_buf_tail;
  logic [1:0]            r_buf_occ;
  logic [DATA_WIDTH-1:0] r_buf [0:2];
  logic                  r_in_ready;
  logic                  r_csb0;
  logic                  r_web0;
  logic                  r_csb1;
  logic [MACRO_AW-1:0]   r_addr0;
  logic [MACRO_AW-1:0]   r_addr1;
  logic [DATA_WIDTH-1:0] r_din0;

  logic                  w_flush;
  logic                  w_clear;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic [1:0]            w_inflight;
  logic [2:0]            w_used;
  logic [2:0]            w_limit;
  logic [CW-1:0]         w_mem_cnt_next;
  logic [CW-1:0]         w_rd_avail_next;
  logic [1:0]            w_occ_next;

`ifdef SFC_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_clear = !rstb0 || w_flush;

  function automatic logic [1:0] wrap3_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_push     = in_valid && r_in_ready && !w_flush;
  assign w_pop      = (r_buf_occ != 2'd0) && out_ready && !w_flush;
  assign w_inflight = {1'b0, r_pipe[0]} + {1'b0, r_pipe[1]};

  // A buffer slot freed by this cycle's pop counts as free, so a read can be
  // issued into it; without this the 2-cycle read pipe leaves a bubble every
  // few bytes when streaming.
  assign w_used  = {1'b0, r_buf_occ} + {1'b0, w_inflight};
  assign w_limit = 3'd3 + {2'b00, w_pop};
  assign w_issue = (r_rd_avail != '0) && !w_flush && (w_used < w_limit);

  assign w_mem_cnt_next  = r_mem_cnt + CW'(w_push) - CW'(w_issue);
  // Pushes become readable one cycle late so the macro's write (committed at
  // the negedge after capture) lands before any read of the same address.
  assign w_rd_avail_next = r_rd_avail + CW'(r_push_d1) - CW'(w_issue);
  assign w_occ_next      = r_buf_occ + {1'b0, r_pipe[1]} - {1'b0, w_pop};

  always_ff @(posedge clk0) begin
    if (w_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_mem_cnt  <= '0;
      r_rd_avail <= '0;
      r_push_d1  <= 1'b0;
      r_pipe     <= '0;
      r_buf_head <= '0;
      r_buf_tail <= '0;
      r_buf_occ  <= '0;
      for (int i = 0; i < 3; i++) begin
        r_buf[i] <= '0;
      end
      // Low while reset is held, high straight away after a flush.
      r_in_ready <= rstb0;
      r_csb0     <= 1'b1;
      r_web0     <= 1'b1;
      r_csb1     <= 1'b1;
      r_addr0    <= '0;
      r_addr1    <= '0;
      r_din0     <= '0;
    end else begin
      r_mem_cnt  <= w_mem_cnt_next;
      r_rd_avail <= w_rd_avail_next;
      r_push_d1  <= w_push;
      r_in_ready <= (w_mem_cnt_next < DEPTH_C);
      r_csb0     <= !w_push;
      r_web0     <= !w_push;
      if (w_push) begin
        r_addr0  <= {{(MACRO_AW-ADDR_WIDTH){1'b0}}, r_wr_ptr};
        r_din0   <= in_data;
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      r_csb1 <= !w_issue;
      if (w_issue) begin
        r_addr1  <= {{(MACRO_AW-ADDR_WIDTH){1'b0}}, r_rd_ptr};
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      r_pipe <= {r_pipe[0], w_issue};
      if (r_pipe[1]) begin
        r_buf[r_buf_tail] <= sram_dout1;
        r_buf_tail        <= wrap3_inc(r_buf_tail);
      end
      if (w_pop) begin
        r_buf_head <= wrap3_inc(r_buf_head);
      end
      r_buf_occ <= w_occ_next;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = (r_buf_occ != 2'd0);
  assign out_data   = r_buf[r_buf_head];
  assign level      = r_mem_cnt + CW'(w_inflight) + CW'(r_buf_occ);
  assign sram_csb0  = r_csb0;
  assign sram_web0  = r_web0;
  assign sram_addr0 = r_addr0;
  assign sram_din0  = r_din0;
  assign sram_csb1  = r_csb1;
  assign sram_addr1 = r_addr1;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_fifo_ctrl
// Bench for sram_fifo_ctrl with a behavioural model of the 1r1w SRAM macro.
// The reference model is a plain byte queue with accept timestamps: level is
// the queue size, the head must be shown exactly once it is 4 edges old, and
// the write/read ports must walk addresses 0..1023 in order.
// -----------------------------------------------------------------------------
module tb_sram_fifo_ctrl;

  logic        clk0;
  logic        rstb0;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [10:0] level;
  logic        sram_csb0;
  logic        sram_web0;
  logic [11:0] sram_addr0;
  logic [7:0]  sram_din0;
  logic        sram_csb1;
  logic [11:0] sram_addr1;
  logic [7:0]  sram_dout1;
  logic        flush;

  sram_fifo_ctrl dut (
    .clk0       (clk0),
    .rstb0      (rstb0),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .level      (level),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1)
`ifdef SFC_FLUSH_EN
    ,
    .flush      (flush)
`endif
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  always @(posedge clk0) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM macro model ----------------
  logic [7:0] mem [0:1023];
  logic       m_wr_pend = 1'b0;
  logic [9:0] m_wr_addr;
  logic [7:0] m_wr_data;
  logic       m_rd_pend = 1'b0;
  logic [9:0] m_rd_addr;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;
    sram_dout1 = 8'h00;
  end

  always @(posedge clk0) begin
    m_wr_pend <= !sram_csb0 && !sram_web0;
    m_wr_addr <= sram_addr0[9:0];
    m_wr_data <= sram_din0;
    m_rd_pend <= !sram_csb1;
    m_rd_addr <= sram_addr1[9:0];
  end

  always @(negedge clk0) begin
    if (m_wr_pend) mem[m_wr_addr] <= m_wr_data;
    if (m_rd_pend) sram_dout1 <= (m_wr_pend && m_wr_addr == m_rd_addr) ? m_wr_data : mem[m_rd_addr];
  end

  // ---------------- reference model + compare process ----------------
  logic [7:0] mq[$];
  int         tq[$];
  logic       in_rst = 1'b1;
  logic       exp_wr = 1'b0;
  logic [9:0] exp_wr_addr;
  logic [7:0] exp_wr_data;
  logic [9:0] wr_idx = '0;
  logic [9:0] rd_idx = '0;

  always @(negedge clk0) begin
    int t;
    t = edge_cnt;
    if (in_rst) begin
      chk("rst_in_ready", {31'b0, in_ready}, 0);
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_level", {21'b0, level}, 0);
      chk("rst_csb_web", {29'b0, sram_csb0, sram_web0, sram_csb1}, 32'h7);
      chk("rst_addr_data", {sram_addr0, sram_addr1, sram_din0}, 0);
      chk("rst_out_data", {24'b0, out_data}, 0);
    end else begin
      chk("level", {21'b0, level}, mq.size());
      chk("out_valid", {31'b0, out_valid}, (mq.size() > 0 && tq[0] + 4 <= t) ? 1 : 0);
      if (out_valid && mq.size() > 0) chk("out_data", {24'b0, out_data}, {24'b0, mq[0]});
      if (mq.size() < 1024) chk("in_ready_room", {31'b0, in_ready}, 1);
      if (mq.size() >= 1027) chk("in_ready_full", {31'b0, in_ready}, 0);
      if (exp_wr) begin
        chk("wr_port", {sram_csb0, sram_web0, sram_addr0, sram_din0},
            {2'b00, 2'b00, exp_wr_addr, exp_wr_data});
      end else begin
        chk("wr_idle", {30'b0, sram_csb0, sram_web0}, 32'h3);
      end
      if (!sram_csb1) begin
        chk("rd_addr", {20'b0, sram_addr1}, {22'b0, rd_idx});
        rd_idx = rd_idx + 10'd1;
      end
    end
    // What the coming edge does to the model.
    exp_wr = 1'b0;
    if (!rstb0 || flush) begin
      mq.delete();
      tq.delete();
      wr_idx = '0;
      rd_idx = '0;
      in_rst = !rstb0;
    end else begin
      in_rst = 1'b0;
      if (out_valid && out_ready && mq.size() > 0) begin
        $display("[%0d] pop %02h level %0d", t + 1, out_data, level);
        void'(mq.pop_front());
        void'(tq.pop_front());
      end
      if (in_valid && in_ready) begin
        mq.push_back(in_data);
        tq.push_back(t + 1);
        exp_wr      = 1'b1;
        exp_wr_addr = wr_idx;
        exp_wr_data = in_data;
        wr_idx      = wr_idx + 10'd1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  task automatic drain(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 1200 && level != 0; c++) step();
    chk(name, {21'b0, level}, 0);
    out_ready = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int drop_at;
    int nvalid;
    int bubbles;
    int maxlvl;
    bit seen;

    rstb0 = 1'b0; in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0; flush = 1'b0;
    repeat (3) step();
    rstb0 = 1'b1; in_valid = 1'b0;
    step();
    chk("in_ready_after_release", {31'b0, in_ready}, 1);
    $display("reset done, in_ready=%0d", in_ready);

    // Fall-through of one byte.
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    chk("ft_wr", {sram_csb0, sram_web0, sram_addr0, sram_din0}, {2'b00, 12'h000, 8'hA5});
    step(); step();
    chk("ft_rd", {sram_csb1, sram_addr1}, {1'b0, 12'h000});
    step();
    chk("ft_not_yet", {31'b0, out_valid}, 0);
    step();
    chk("ft_out", {out_valid, out_data, level}, {1'b1, 8'hA5, 11'd1});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("ft_popped", {out_valid, level}, {1'b0, 11'd0});
    $display("fall-through done");

    // Streaming 0x00..0xFF with continuous pop.
    nvalid = 0; bubbles = 0; maxlvl = 0; seen = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 270; c++) begin
      in_valid = (c < 256);
      in_data  = 8'(c);
      step();
      if (int'(level) > maxlvl) maxlvl = int'(level);
      if (out_valid) begin
        seen = 1;
        nvalid++;
      end else if (seen && nvalid < 256) begin
        bubbles++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stream_count", nvalid, 256);
    chk("stream_bubbles", bubbles, 0);
    chk("stream_level_le5", (maxlvl <= 5) ? 1 : 0, 1);
    chk("stream_max_level", maxlvl, 5);
    $display("streaming done, max level %0d", maxlvl);

    // Fill to full without popping.
    acc = 0; drop_at = -1;
    for (int k = 0; k < 1030; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(k * 7 + 3);
      if (in_ready) acc++;
      else if (drop_at < 0) drop_at = acc;
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("full_accepted", acc, 1027);
    chk("full_drop_point", drop_at, 1027);
    chk("full_level", {21'b0, level}, 1027);
    chk("full_in_ready", {31'b0, in_ready}, 0);
    $display("full done, accepted %0d", acc);
    drain("full_drain");

    // Second fill with intermittent pops; pointers wrap again.
    for (int c = 0; c < 1100; c++) begin
      in_valid  = 1'b1;
      in_data   = 8'(c) ^ 8'h5A;
      out_ready = (c % 3 != 0);
      step();
    end
    drain("wrap_drain");
    $display("wrap-around done");

    // Level held at 10 with simultaneous push and pop.
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_data = 8'(8'hC0 + c);
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();
    chk("simul_start_level", {21'b0, level}, 10);
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; out_ready = 1'b1; in_data = 8'(8'h30 + c);
      step();
      chk("simul_level", {21'b0, level}, 10);
    end
    drain("simul_drain");
    $display("simultaneous done");

`ifdef SFC_FLUSH_EN
    in_valid = 1'b1; in_data = 8'h61;
    step();
    in_data = 8'h62;
    step();
    in_valid = 1'b0;
    step(); step();
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h63;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_state", {out_valid, level, in_ready}, {1'b0, 11'd0, 1'b1});
    repeat (4) step();
    chk("flush_no_stale", {31'b0, out_valid}, 0);
    in_valid = 1'b1; in_data = 8'h7E;
    step();
    in_valid = 1'b0;
    chk("flush_wr_addr", {sram_csb0, sram_addr0}, {1'b0, 12'h000});
    step(); step();
    chk("flush_rd_addr", {sram_csb1, sram_addr1}, {1'b0, 12'h000});
    step(); step();
    chk("flush_out", {out_valid, out_data}, {1'b1, 8'h7E});
    drain("flush_drain");
    $display("flush done");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
